// File: rtl/uart_pkg.sv
// +----------------------------------------------------------------------+
// | uart_pkg: shared state encoding and line levels for the UART receiver |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam logic START_BIT         = 1'b0;
  localparam logic STOP_BIT          = 1'b1;
  localparam int   DATA_BITS_DEFAULT = 8;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// +----------------------------------------------------------------------+
// | sync_2ff: two-flop synchronizer, resets to the idle line level (1)    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_2ff (
  input  logic pulse,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge pulse) begin
    if (reset) begin
      meta_q <= 1'b1;
      q      <= 1'b1;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_sipo_receiver.sv
// +----------------------------------------------------------------------+
// | uart_sipo_receiver: oversampled 8N1 UART receiver, midpoint sampling  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module uart_sipo_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = DATA_BITS_DEFAULT
) (
  input  logic                 pulse,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic                 RxIn,
  output logic [DATA_BITS-1:0] RxData,
  output logic                 RxValid,
  output logic                 FrameError,
  output logic                 Busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] MID_TICK  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  rx_state_t            state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 rx_s;

  sync_2ff u_sync (
    .pulse (pulse),
    .reset (reset),
    .d     (RxIn),
    .q     (rx_s)
  );

  always_ff @(posedge pulse) begin
    if (reset) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (sample_en) begin
      case (state_q)
        IDLE: begin
          if (rx_s == START_BIT) begin
            state_d = START;
            tick_d  = '0;
          end
        end
        START: begin
          // A start bit that is high again at its midpoint was only a glitch.
          if (tick_q == MID_TICK) begin
            tick_d  = '0;
            bit_d   = '0;
            state_d = (rx_s == START_BIT) ? DATA : IDLE;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        DATA: begin
          if (tick_q == LAST_TICK) begin
            shift_d[bit_q] = rx_s;
            tick_d         = '0;
            if (bit_q == LAST_BIT) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        STOP: begin
          if (tick_q == LAST_TICK) begin
            tick_d = '0;
            if (rx_s == STOP_BIT) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        BREAK: begin
          // Wait out a held-low line so it cannot masquerade as new start bits.
          if (rx_s == STOP_BIT) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    Busy       = (state_q != IDLE);
    RxData     = data_q;
    RxValid    = valid_q;
    FrameError = ferr_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_sipo_receiver.sv
// +----------------------------------------------------------------------+
// | tb_uart_sipo_receiver: directed frames checked against a tick model   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_uart_sipo_receiver;

  localparam int OS = 16;
  localparam int DB = 8;

  logic          pulse     = 1'b0;
  logic          reset     = 1'b1;
  logic          sample_en = 1'b0;
  logic          RxIn      = 1'b1;
  logic [DB-1:0] RxData;
  logic          RxValid;
  logic          FrameError;
  logic          Busy;

  uart_sipo_receiver #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .pulse      (pulse),
    .reset      (reset),
    .sample_en  (sample_en),
    .RxIn       (RxIn),
    .RxData     (RxData),
    .RxValid    (RxValid),
    .FrameError (FrameError),
    .Busy       (Busy)
  );

  always #5 pulse = ~pulse;

  int total  = 0;
  int bad    = 0;
  int ecount = 0;
  int se_div = 1;

  always @(posedge pulse) ecount++;

  always @(posedge pulse) begin
    #1;
    sample_en = ((ecount % se_div) == 0);
  end

  // Reference: counts sample ticks since start detection and samples the
  // synchronized line at the offsets where each bit's midpoint must fall.
  logic          m_s1    = 1'b1;
  logic          m_s2    = 1'b1;
  logic          m_valid = 1'b0;
  logic          m_ferr  = 1'b0;
  logic [DB-1:0] m_data  = '0;
  logic [DB-1:0] m_shift = '0;
  int            m_mode  = 0;
  int            m_rel   = 0;

  always @(posedge pulse) begin : model
    logic rxs;
    int   k;
    rxs = m_s2;
    if (reset) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_valid = 1'b0; m_ferr = 1'b0;
      m_data = '0; m_shift = '0; m_mode = 0; m_rel = 0;
    end else begin
      m_s2 = m_s1;
      m_s1 = RxIn;
      m_valid = 1'b0;
      m_ferr  = 1'b0;
      if (sample_en) begin
        if (m_mode == 0) begin
          if (!rxs) begin
            m_mode = 1;
            m_rel  = 0;
          end
        end else if (m_mode == 1) begin
          m_rel++;
          if (m_rel == OS / 2) begin
            if (rxs) m_mode = 0;
          end else if (m_rel > OS / 2 && ((m_rel - OS / 2) % OS) == 0) begin
            k = (m_rel - OS / 2) / OS - 1;
            if (k < DB) begin
              m_shift[k] = rxs;
            end else if (rxs) begin
              m_data  = m_shift;
              m_valid = 1'b1;
              m_mode  = 0;
            end else begin
              m_ferr = 1'b1;
              m_mode = 2;
            end
          end
        end else if (rxs) begin
          m_mode = 0;
        end
      end
    end
  end

  int            n_valid     = 0;
  int            n_ferr      = 0;
  int            busy_cycles = 0;
  int            prints      = 0;
  logic [DB-1:0] got_q[$];
  int            vedge_q[$];

  always @(negedge pulse) begin
    total++;
    if (RxValid !== m_valid || FrameError !== m_ferr || RxData !== m_data ||
        Busy !== (m_mode != 0)) begin
      bad++;
      if (prints < 20) begin
        prints++;
        $display("FAIL model_cmp edge=%0d got v=%b fe=%b d=%h busy=%b want v=%b fe=%b d=%h busy=%b",
                 ecount, RxValid, FrameError, RxData, Busy,
                 m_valid, m_ferr, m_data, (m_mode != 0));
      end
    end
    if (RxValid) begin
      n_valid++;
      got_q.push_back(RxData);
      vedge_q.push_back(ecount);
    end
    if (FrameError) n_ferr++;
    if (Busy) busy_cycles++;
  end

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge pulse);
    #2;
  endtask

  task automatic hold(input logic v, input int n);
    RxIn = v;
    repeat (n) step();
  endtask

  task automatic send(input logic [DB-1:0] b, input logic stopb, input int bitc);
    hold(1'b0, bitc);
    for (int i = 0; i < DB; i++) hold(b[i], bitc);
    hold(stopb, bitc);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int t0, v0, f0, lat;
    reset = 1'b1;
    RxIn  = 1'b1;
    repeat (3) step();
    chk("rst_data",  RxData,     0);
    chk("rst_busy",  Busy,       0);
    chk("rst_valid", RxValid,    0);
    chk("rst_ferr",  FrameError, 0);
    reset = 1'b0;
    hold(1'b1, 20);

    // 0xAA followed by 0x55 with no idle gap
    v0 = n_valid;
    f0 = n_ferr;
    t0 = ecount;
    send(8'hAA, 1'b1, OS);
    send(8'h55, 1'b1, OS);
    hold(1'b1, 30);
    chk("b2b_count", n_valid - v0, 2);
    if (n_valid - v0 >= 2) begin
      chk("aa_data",    got_q[v0],          8'hAA);
      chk("aa_latency", vedge_q[v0] - t0,   155);
      chk("55_data",    got_q[v0 + 1],      8'h55);
    end
    chk("b2b_no_ferr", n_ferr - f0, 0);

    // 0xC3 with a low stop bit, then the line stays low
    v0 = n_valid;
    f0 = n_ferr;
    send(8'hC3, 1'b0, OS);
    hold(1'b0, 20);
    chk("break_busy", Busy, 1);
    hold(1'b0, 20);
    hold(1'b1, 40);
    chk("fe_count",     n_ferr - f0,  1);
    chk("fe_no_valid",  n_valid - v0, 0);
    chk("fe_data_kept", RxData,       8'h55);
    chk("fe_idle",      Busy,         0);

    // 4-cycle glitch on an idle line
    v0 = n_valid;
    f0 = n_ferr;
    busy_cycles = 0;
    hold(1'b0, 4);
    hold(1'b1, 40);
    chk("glitch_busy", busy_cycles, 8);
    chk("glitch_strobes", (n_valid - v0) + (n_ferr - f0), 0);

    // reset in the middle of data bit 3 of 0xF0
    hold(1'b0, OS);
    hold(1'b0, OS * 3);
    hold(1'b0, OS / 2);
    reset = 1'b1;
    RxIn  = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_busy",  Busy,    0);
    chk("midrst_data",  RxData,  0);
    chk("midrst_valid", RxValid, 0);
    hold(1'b1, 30);

    v0 = n_valid;
    t0 = ecount;
    send(8'h0F, 1'b1, OS);
    hold(1'b1, 30);
    chk("0f_count", n_valid - v0, 1);
    if (n_valid - v0 >= 1) begin
      chk("0f_data",    got_q[v0],        8'h0F);
      chk("0f_latency", vedge_q[v0] - t0, 155);
    end

    // one sample tick every 4 cycles
    se_div = 4;
    hold(1'b1, 40);
    v0 = n_valid;
    t0 = ecount;
    send(8'h81, 1'b1, 4 * OS);
    hold(1'b1, 100);
    chk("81_count", n_valid - v0, 1);
    if (n_valid - v0 >= 1) begin
      chk("81_data", got_q[v0], 8'h81);
      lat = vedge_q[v0] - t0;
      chk("81_latency_range", int'(lat >= 611 && lat <= 614), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
